uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - Serial receiver for the RS232-like single-line link driven by the team's UART transmitter.
// - Deserialises each frame into one parallel data word.
//   Frame on the line: start bit (low), data bits LSB first, optional even-parity bit, 0..2 stop bits (high).
// - Raises a one-cycle valid strobe per frame and flags parity or framing faults.
// - Sits between the board RX pin and the command/readout logic.
// PARAMETERS
// C_CLK_FRQ          100_000_000  clock frequency [Hz]
// C_UART_RATE        1_000_000    bit rate [baud]; C_PERIOD = C_CLK_FRQ/C_UART_RATE, must be >= 4
// C_UART_DATA_WIDTH  8            data bits per frame
// C_UART_PARITY      1            1: parity bit present (even, = XOR of data bits); 0: none
// C_UART_STOP        1            stop bits per frame {0,1,2}
// PORTS
// clk    in   1                  master clock
// rst    in   1                  synchronous reset, active high
// rx     in   1                  serial line, asynchronous, idles high
// data   out  C_UART_DATA_WIDTH  last received word, bit 0 = first data bit on line
// valid  out  1                  one-cycle strobe: data/error updated this cycle
// busy   out  1                  high while a frame is being received
// error  out  1                  parity or framing error for the word currently on data
// BEHAVIOUR
// - Reset values
//   - On rst: data=0, valid=0, busy=0, error=0, FSM -> sIDLE.
//   - Synchroniser flops reset to 1.
//   - Reset mid-frame aborts the frame; no valid is issued for it.
// - Input path: rx passes a 2-flop synchroniser (2 cycles latency); the FSM uses only the synced value.
// - Counters
//   - Cycle counter width $clog2(C_PERIOD+1).
//   - Bit counter width $clog2(C_UART_DATA_WIDTH+C_UART_STOP+1).
// - FSM sIDLE
//   - Requires the synced line seen high on the previous cycle, then low on this cycle (falling edge).
//   - On that edge: -> sSTART, cycle counter cleared.
// - FSM sSTART
//   - After C_PERIOD/2 cycles (integer division), sample the line.
//   - Line low: -> sDATA, counter cleared.
//   - Line high: glitch -> sIDLE, no valid, no error.
// - FSM sDATA
//   - Sample every C_PERIOD cycles into a shift register, LSB first.
//   - After C_UART_DATA_WIDTH samples -> sPARITY if C_UART_PARITY=1.
//   - Otherwise -> sSTOP if C_UART_STOP>0, else -> sDONE.
// - FSM sPARITY: sample one bit after C_PERIOD cycles.
//   - Parity error if XOR(data bits, parity bit) = 1.
//   - -> sSTOP, or -> sDONE if C_UART_STOP=0.
// - FSM sSTOP: sample C_UART_STOP bits, each after C_PERIOD cycles.
//   - Any low sample sets a framing error.
//   - Sampling continues through all stop bits; then -> sDONE.
// - FSM sDONE (1 cycle)
//   - data <= shift register.
//   - error <= parity_err | framing_err.
//   - valid=1 for exactly this cycle; next state is sIDLE.
// - Timing and output rules
//   - Latency: valid asserts 1 cycle after the final sample.
//     The final sample is ~(C_PACKET_SIZE-0.5)*C_PERIOD cycles after the start edge, plus 2 sync cycles.
//   - valid pulses on every completed frame, including errored ones; error qualifies it.
//   - data and error hold until the next valid.
//   - busy = (state != sIDLE), registered.
// - Back-to-back frames: a start edge right after the last stop bit must be caught.
//   - sIDLE is entered mid-stop-bit, so the falling edge is still seen.
//   - With C_UART_STOP=0, a new frame needs the line high for >=1 cycle before its start edge.
// - Tolerance: frames from a transmitter within +/-2% of C_UART_RATE must decode correctly.
// - Clocked errors are not sticky across frames; there is no error-clear input.
// TESTING (defaults: C_PERIOD=100, 8 data bits, parity on, 1 stop bit; stimulus from a behavioural TX model)
// 1. Send 0xA5 (parity 0) -> single valid pulse, data=0xA5, error=0, busy falls on the cycle after valid.
// 2. Send 0x01 with parity bit forced 0 -> valid, data=0x01, error=1; next clean 0x02 -> error=0.
// 3. Send 0x3C with stop bit forced low -> valid, data=0x3C, error=1.
// 4. 30-cycle low glitch on idle line -> busy rises then falls ~52 cycles later; no valid.
// 5. rst pulsed during bit 4 of 0xFF, then send 0x42 -> exactly one valid, data=0x42, error=0.
// 6. Back-to-back 0x00,0xFF,0x55 at +2% and -2% baud, no idle gap -> three valids, correct data, error=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver. Each frame is a start bit (low),
// LSB-first data bits, an optional even-parity bit and 0..2 stop bits (high).
// Every completed frame gives one data word, a one-cycle valid strobe and an
// error flag for parity or framing faults.
//
// Handshake: valid is a push-only strobe with no ready. data and error are
// updated on the cycle valid is high and hold until the next valid. The
// consumer must take the word on that cycle.
module uart_rx #(
   parameter int C_CLK_FRQ         = 100_000_000,
   parameter int C_UART_RATE       = 1_000_000,
   parameter int C_UART_DATA_WIDTH = 8,
   parameter int C_UART_PARITY     = 1,
   parameter int C_UART_STOP       = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx,
   output logic [C_UART_DATA_WIDTH-1:0] data,
   output logic                         valid,
   output logic                         busy,
   output logic                         error
);

   localparam int C_PERIOD = C_CLK_FRQ / C_UART_RATE;
   localparam int CW       = $clog2(C_PERIOD + 1);
   localparam int BW       = $clog2(C_UART_DATA_WIDTH + C_UART_STOP + 1);
   localparam int W        = C_UART_DATA_WIDTH;

   // Counter end values. Samples are taken when the cycle counter reaches these values.
   localparam logic [CW-1:0] HALF_LAST = CW'(C_PERIOD / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(C_PERIOD - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(C_UART_DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(C_UART_STOP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   // state is left as a plain named signal so that checkers can bind to it.
   state_t          state, state_next;
   logic            rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]   cyc_cnt, cyc_next;
   logic [BW-1:0]   bit_cnt, bit_next;
   logic [W-1:0]    shift, shift_next;
   logic            par_err, par_next;
   logic            frm_err, frm_next;

   // Two-flop synchroniser plus a delayed copy for start-edge detection.
   // These flops reset to the idle line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Frame sequencing: next state, counters, shift register and error flags.
   always_comb begin
      state_next = state;
      cyc_next   = cyc_cnt + CW'(1);
      bit_next   = bit_cnt;
      shift_next = shift;
      par_next   = par_err;
      frm_next   = frm_err;
      case (state)
         S_IDLE: begin
            cyc_next = '0;
            if (rx_prev && !rx_sync) begin
               state_next = S_START;
               bit_next   = '0;
               par_next   = 1'b0;
               frm_next   = 1'b0;
            end
         end
         S_START: begin
            // Check at mid start bit. If the line is high again, the low pulse was a glitch.
            if (cyc_cnt == HALF_LAST) begin
               cyc_next   = '0;
               state_next = rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cyc_cnt == FULL_LAST) begin
               cyc_next   = '0;
               shift_next = {rx_sync, shift[W-1:1]};
               if (bit_cnt == DATA_LAST) begin
                  bit_next = '0;
                  if (C_UART_PARITY != 0)
                     state_next = S_PARITY;
                  else if (C_UART_STOP > 0)
                     state_next = S_STOP;
                  else
                     state_next = S_DONE;
               end else begin
                  bit_next = bit_cnt + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (cyc_cnt == FULL_LAST) begin
               cyc_next   = '0;
               par_next   = (^shift) ^ rx_sync;
               state_next = (C_UART_STOP > 0) ? S_STOP : S_DONE;
            end
         end
         S_STOP: begin
            // Every stop bit is sampled. Any low stop bit sets the framing error.
            if (cyc_cnt == FULL_LAST) begin
               cyc_next = '0;
               if (!rx_sync)
                  frm_next = 1'b1;
               if (bit_cnt == STOP_LAST) begin
                  bit_next   = '0;
                  state_next = S_DONE;
               end else begin
                  bit_next = bit_cnt + BW'(1);
               end
            end
         end
         S_DONE: begin
            cyc_next   = '0;
            state_next = S_IDLE;
         end
         default: begin
            cyc_next   = '0;
            state_next = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cyc_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         state   <= state_next;
         cyc_cnt <= cyc_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
         par_err <= par_next;
         frm_err <= frm_next;
      end
   end

   // Registered outputs. They load on entry to S_DONE, so valid, data and error
   // change together on the S_DONE cycle, and busy drops on the cycle after that.
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         error <= 1'b0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         valid <= (state_next == S_DONE);
         busy  <= (state_next != S_IDLE);
         if (state_next == S_DONE) begin
            data  <= shift_next;
            error <= par_next | frm_next;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives uart_rx from a behavioural serial transmitter. A scoreboard
// queue holds the expected {error, data} pairs, and a monitor compares them on every valid.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       error;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] exp_q[$];   // {error, data}
   bit         chk_next = 1'b0;

   uart_rx dut (
      .clk   (clk),
      .rst   (rst),
      .rx    (rx),
      .data  (data),
      .valid (valid),
      .busy  (busy),
      .error (error)
   );

   // Clock: 10 time units per cycle.
   always #5 clk = ~clk;

   // Watchdog: stops the run if it goes far past its expected length.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded cycle budget, pending=%0d", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Driver: hold one line level for bl clock cycles.
   task automatic drive_bit(input logic v, input int bl);
      rx = v;
      repeat (bl) @(negedge clk);
   endtask

   // Behavioural transmitter plus reference model. The expected word is the
   // sent byte. The error flag is set when the parity or stop bit is corrupted.
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int bl);
      exp_q.push_back({bad_par | bad_stop, d});
      drive_bit(1'b0, bl);
      for (int i = 0; i < 8; i++)
         drive_bit(d[i], bl);
      drive_bit((^d) ^ bad_par, bl);
      drive_bit(!bad_stop, bl);
      rx = 1'b1;
   endtask

   // Monitor: compare each output word with the scoreboard. Also check that valid
   // lasts one cycle and that busy is low on the following cycle.
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst) begin
         chk_next = 1'b0;
      end else begin
         if (chk_next) begin
            check("valid_single_cycle", valid, 0);
            check("busy_after_valid", busy, 0);
            chk_next = 1'b0;
         end
         if (valid) begin
            check("valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rx_data", data, e[7:0]);
               check("rx_error", error, e[8]);
            end
            chk_next = 1'b1;
         end
      end
   end

   // Stimulus sequence.
   initial begin
      int hi;
      logic [7:0] d;
      bit bp, bs;
      int bl, gap;

      // Clock/reset
      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_data", data, 0);
      check("reset_valid", valid, 0);
      check("reset_busy", busy, 0);
      check("reset_error", error, 0);
      repeat (20) @(negedge clk);

      // Clean frame
      send_frame(8'hA5, 1'b0, 1'b0, 100);
      repeat (50) @(negedge clk);

      // Parity fault, then a clean word clears the error
      send_frame(8'h01, 1'b1, 1'b0, 100);
      repeat (50) @(negedge clk);
      send_frame(8'h02, 1'b0, 1'b0, 100);
      repeat (50) @(negedge clk);

      // Framing fault
      send_frame(8'h3C, 1'b0, 1'b1, 100);
      repeat (50) @(negedge clk);

      // Low glitch on the idle line: busy goes high briefly and no valid appears
      rx = 1'b0;
      hi = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (i == 29) rx = 1'b1;
         if (busy) hi++;
      end
      check("glitch_busy_cycles_in_range", (hi >= 45 && hi <= 60), 1);
      check("glitch_busy_end", busy, 0);

      // Reset during bit 4 of 0xFF aborts that frame
      drive_bit(1'b0, 100);
      drive_bit(1'b1, 450);
      check("busy_mid_frame", busy, 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midreset_data", data, 0);
      check("midreset_error", error, 0);
      check("midreset_busy", busy, 0);
      repeat (200) @(negedge clk);
      send_frame(8'h42, 1'b0, 1'b0, 100);
      repeat (50) @(negedge clk);

      // Back-to-back frames with no gap, at fast and slow transmitter rates
      send_frame(8'h00, 1'b0, 1'b0, 98);
      send_frame(8'hFF, 1'b0, 1'b0, 98);
      send_frame(8'h55, 1'b0, 1'b0, 98);
      send_frame(8'h00, 1'b0, 1'b0, 102);
      send_frame(8'hFF, 1'b0, 1'b0, 102);
      send_frame(8'h55, 1'b0, 1'b0, 102);
      repeat (50) @(negedge clk);

      // Random frames: random data, faults, rate error and idle gap
      for (int n = 0; n < 20; n++) begin
         d   = 8'($urandom_range(0, 255));
         bp  = ($urandom_range(0, 3) == 0);
         bs  = ($urandom_range(0, 3) == 0);
         bl  = $urandom_range(98, 102);
         gap = bs ? $urandom_range(2, 20) : $urandom_range(0, 20);
         send_frame(d, bp, bs, bl);
         repeat (gap) @(negedge clk);
      end

      // Wait for outstanding expectations, then print the final report
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++)
         @(negedge clk);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
